// File: rtl/uart_tx_if.sv
// Transmit-side handshake and line signals of the UART transmitter, shared by source and DUT.
interface uart_tx_if #(
  parameter int UART_SIZE = 8
);
  logic [UART_SIZE-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 CTS;
  logic                 TX;
  logic                 busy;
  logic                 done;

  modport master (
    output tx_data, tx_valid, CTS,
    input  tx_ready, TX, busy, done
  );

  modport slave (
    input  tx_data, tx_valid, CTS,
    output tx_ready, TX, busy, done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit, CTS-gated accept.
// TX is registered, so the line value is derived from the next state.
module uart_tx #(
  parameter int UART_SIZE     = 8,
  parameter int BAUD_RATE     = 115200,
  parameter int SYS_CLK_FREQ  = 125000000,
  parameter int PARITY_ENABLE = 0,
  parameter int PARITY_TYPE   = 0
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);
  localparam int BAUD_TICKS = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BAUD_TICKS + 1);
  localparam int BIT_W      = $clog2(UART_SIZE + 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_TICKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [UART_SIZE-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 ready;
  logic                 accept;
  logic                 baud_done;

  assign ready     = (state_q == IDLE) && bus.CTS && !reset;
  assign accept    = bus.tx_valid && ready;
  assign baud_done = (baud_q == BAUD_LAST);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      // NOTE: the shift register is cleared too, so no stale byte survives an aborted frame.
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          baud_d   = '0;
          bit_d    = '0;
          shift_d  = bus.tx_data;
          parity_d = (PARITY_TYPE == 0) ? ~^bus.tx_data : ^bus.tx_data;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_ENABLE != 0) ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (baud_done) begin
          state_d = STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; the line value is chosen for the state being entered.
  always_comb begin
    tx_d     = 1'b1;
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == STOP) && baud_done && !reset;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx_ready = ready;
  assign bus.TX       = tx_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a cycle-count frame model checks every cycle,
// and directed scenarios pin exact bit patterns and done timing with literals.
module tb_uart_tx;
  localparam int T = 125000000 / 115200;  // 1085 clocks per bit

  logic clk = 1'b0;
  logic reset;
  always #4 clk = ~clk;

  uart_tx_if #(.UART_SIZE(8)) m_if (), po_if (), pe_if ();

  uart_tx u_m (.clk(clk), .reset(reset), .bus(m_if));
  uart_tx #(.PARITY_ENABLE(1), .PARITY_TYPE(0)) u_po (.clk(clk), .reset(reset), .bus(po_if));
  uart_tx #(.PARITY_ENABLE(1), .PARITY_TYPE(1)) u_pe (.clk(clk), .reset(reset), .bus(pe_if));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a list of bits, each lasting T cycles, starting the cycle after accept.
  bit         md_live [3] = '{0, 0, 0};
  bit         md_in   [3] = '{0, 0, 0};
  int         md_t    [3] = '{0, 0, 0};
  logic [10:0] md_bits [3];
  int         md_len  [3] = '{10, 11, 11};
  int         md_ptype[3] = '{0, 0, 1};

  function automatic logic [10:0] frame_of(input int id, input logic [7:0] d);
    int   ones;
    logic par;
    ones = $countones(d);
    if (md_len[id] == 10) return {2'b01, d, 1'b0};
    par = (md_ptype[id] == 0) ? (ones % 2 == 0) : (ones % 2 == 1);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic step(input int id, input logic tx, input logic busy, input logic done,
                      input logic ready, input logic valid, input logic cts, input logic [7:0] data);
    logic [3:0] exp;
    if (md_live[id]) begin
      exp[3] = md_in[id] ? md_bits[id][md_t[id] / T] : 1'b1;
      exp[2] = md_in[id];
      exp[1] = md_in[id] && (md_t[id] == md_len[id] * T - 1) && !reset;
      exp[0] = !md_in[id] && cts && !reset;
      check($sformatf("cycle_dut%0d", id), {28'd0, tx, busy, done, ready}, {28'd0, exp});
    end
    if (reset) begin
      md_in[id]   = 1'b0;
      md_live[id] = 1'b1;
    end else if (md_in[id]) begin
      md_t[id]++;
      if (md_t[id] == md_len[id] * T) md_in[id] = 1'b0;
    end else if (valid && cts) begin
      md_in[id]   = 1'b1;
      md_t[id]    = 0;
      md_bits[id] = frame_of(id, data);
    end
  endtask

  always @(negedge clk) begin
    step(0, m_if.TX,  m_if.busy,  m_if.done,  m_if.tx_ready,  m_if.tx_valid,  m_if.CTS,  m_if.tx_data);
    step(1, po_if.TX, po_if.busy, po_if.done, po_if.tx_ready, po_if.tx_valid, po_if.CTS, po_if.tx_data);
    step(2, pe_if.TX, pe_if.busy, pe_if.done, pe_if.tx_ready, pe_if.tx_valid, pe_if.CTS, pe_if.tx_data);
  end

  task automatic send_main(input logic [7:0] d, input bit hold);
    @(posedge clk); #1;
    m_if.tx_data  = d;
    m_if.tx_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) m_if.tx_valid = 1'b0;
  endtask

  // Walks ncyc cycles from frame cycle 0, sampling TX mid-bit and recording done positions.
  task automatic walk_main(input int ncyc, input int act_n, input int act,
                           output logic [23:0] samp, output int d0, output int d1,
                           output int dcnt, output logic tx0);
    samp = '1; d0 = -1; d1 = -1; dcnt = 0; tx0 = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (n == 0) tx0 = m_if.TX;
      if ((n % T) == T / 2 && (n / T) < 24) samp[n / T] = m_if.TX;
      if (m_if.done) begin
        if (dcnt == 0) d0 = n; else d1 = n;
        dcnt++;
      end
      if (n == act_n) begin
        if (act == 1) m_if.tx_valid = 1'b0;
        if (act == 2) m_if.CTS = 1'b0;
      end
    end
  endtask

  logic [23:0] s, pos, pes;
  int          d0, d1, dc, po_at, pe_at, po_dc, pe_dc;
  logic        t0;

  initial begin
    reset = 1'b1;
    m_if.tx_data  = '0; m_if.tx_valid  = 1'b0; m_if.CTS  = 1'b1;
    po_if.tx_data = '0; po_if.tx_valid = 1'b0; po_if.CTS = 1'b1;
    pe_if.tx_data = '0; pe_if.tx_valid = 1'b0; pe_if.CTS = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", m_if.tx_ready, 1);
    check("reset_tx",    m_if.TX,       1);
    check("reset_busy",  m_if.busy,     0);

    // 0x53 on all three instances at once: plain, odd parity, even parity.
    @(posedge clk); #1;
    m_if.tx_data = 8'h53;  m_if.tx_valid = 1'b1;
    po_if.tx_data = 8'h53; po_if.tx_valid = 1'b1;
    pe_if.tx_data = 8'h53; pe_if.tx_valid = 1'b1;
    @(posedge clk); #1;
    m_if.tx_valid = 1'b0; po_if.tx_valid = 1'b0; pe_if.tx_valid = 1'b0;
    s = '1; pos = '1; pes = '1; d0 = -1; dc = 0; po_at = -1; pe_at = -1; po_dc = 0; pe_dc = 0;
    for (int n = 0; n < 11 * T; n++) begin
      @(negedge clk);
      if (n == 0) check("start_low", m_if.TX, 0);
      if ((n % T) == T / 2) begin
        s[n / T]   = m_if.TX;
        pos[n / T] = po_if.TX;
        pes[n / T] = pe_if.TX;
      end
      if (m_if.done)  begin d0 = n; dc++; end
      if (po_if.done) begin po_at = n; po_dc++; end
      if (pe_if.done) begin pe_at = n; pe_dc++; end
    end
    check("frame53_bits",  s[9:0],    10'b1010100110);
    check("frame53_done",  d0,        10849);
    check("frame53_dcnt",  dc,        1);
    check("odd_par_bits",  pos[10:0], 11'b11010100110);
    check("odd_par_done",  po_at,     11934);
    check("odd_par_dcnt",  po_dc,     1);
    check("even_par_bits", pes[10:0], 11'b10010100110);
    check("even_par_done", pe_at,     11934);
    check("even_par_dcnt", pe_dc,     1);

    // CTS low blocks a pending byte; raising it starts the frame next cycle.
    @(posedge clk); #1;
    m_if.CTS = 1'b0; m_if.tx_data = 8'hA5; m_if.tx_valid = 1'b1;
    repeat (5000) @(negedge clk);
    check("cts_low_ready", m_if.tx_ready, 0);
    check("cts_low_tx",    m_if.TX,       1);
    check("cts_low_busy",  m_if.busy,     0);
    @(posedge clk); #1 m_if.CTS = 1'b1;
    @(posedge clk); #1 m_if.tx_valid = 1'b0;
    walk_main(10 * T, -1, 0, s, d0, d1, dc, t0);
    check("cts_start_low", t0,      0);
    check("frameA5_bits",  s[9:0],  10'b1101001010);
    check("frameA5_done",  d0,      10849);

    // Back-to-back 0x00 then 0xFF with tx_valid held.
    @(posedge clk); #1;
    m_if.tx_data = 8'h00; m_if.tx_valid = 1'b1;
    @(posedge clk); #1 m_if.tx_data = 8'hFF;
    walk_main(20 * T + 5, 10 * T + 5, 1, s, d0, d1, dc, t0);
    check("b2b_bits",  s[19:0], 20'b1111111110_1000000000);
    check("b2b_done0", d0,      10849);
    check("b2b_done1", d1,      21700);
    check("b2b_dcnt",  dc,      2);

    // Reset during data bit 3 aborts the frame without a done pulse.
    send_main(8'h53, 1'b0);
    walk_main(4 * T + 500, -1, 0, s, d0, d1, dc, t0);
    check("abort_pre_bits", s[3:0], 4'b0110);
    check("abort_pre_dcnt", dc,     0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_tx",   m_if.TX,   1);
    check("abort_busy", m_if.busy, 0);
    check("abort_done", m_if.done, 0);
    walk_main(2 * T, -1, 0, s, d0, d1, dc, t0);
    check("abort_no_done", dc, 0);
    send_main(8'h53, 1'b0);
    walk_main(10 * T, -1, 0, s, d0, d1, dc, t0);
    check("after_abort_bits", s[9:0], 10'b1010100110);
    check("after_abort_done", d0,     10849);

    // CTS dropped during data bit 2 must not disturb the frame.
    send_main(8'h53, 1'b0);
    walk_main(10 * T, 3 * T + 500, 2, s, d0, d1, dc, t0);
    check("cts_drop_bits", s[9:0], 10'b1010100110);
    check("cts_drop_done", d0,     10849);
    check("cts_drop_dcnt", dc,     1);
    @(posedge clk); #1 m_if.CTS = 1'b1;

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter UART_SIZE, default 8, giving data bits per frame.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, giving the line rate in bps.
REQ-003 The block SHALL have parameter SYS_CLK_FREQ, default 125000000, giving the clk frequency in Hz.
REQ-004 The block SHALL have parameter PARITY_ENABLE, default 0; 1 inserts a parity bit.
REQ-005 The block SHALL have parameter PARITY_TYPE, default 0; 0 = odd, 1 = even.
REQ-006 The block SHALL derive BAUD_TICKS = SYS_CLK_FREQ / BAUD_RATE (integer division; 1085 at defaults).
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 tx_data  input  UART_SIZE  byte to transmit, sampled on accept.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  block can accept a byte this cycle.
REQ-012 CTS  input  1  active-high clear-to-send from far end.
REQ-013 TX  output  1  serial line, idle high.
REQ-014 busy  output  1  frame in progress.
REQ-015 done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 tx_ready SHALL equal (state == IDLE) && CTS && !reset, combinationally.
REQ-018 Accept SHALL occur on a cycle with tx_valid && tx_ready; tx_data latched into a shift register, state -> START.
REQ-019 TX SHALL be registered; TX goes low the cycle after accept (latency 1).
REQ-020 Each of START, every DATA bit, PARITY and STOP SHALL hold TX for exactly BAUD_TICKS cycles, timed by a baud counter that restarts at 0 on every bit.
REQ-021 DATA SHALL send bits LSB first, UART_SIZE bits, via a bit counter; after the last bit -> PARITY if PARITY_ENABLE else STOP.
REQ-022 Parity bit SHALL be ~^tx_data when PARITY_TYPE=0 (total ones odd), ^tx_data when PARITY_TYPE=1, computed on the latched byte.
REQ-023 STOP SHALL drive TX=1 for one bit; on its final cycle done pulses high for exactly one cycle and state -> IDLE.
REQ-024 Frame length SHALL be (2 + UART_SIZE + PARITY_ENABLE) * BAUD_TICKS cycles from first low TX cycle to STOP end.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 After STOP, at least one IDLE cycle (TX high) SHALL occur before the next start bit; with tx_valid held high and CTS high, next start bit begins exactly 1 cycle after STOP ends... i.e. gap = 1 cycle of TX high beyond the stop bit.
REQ-027 CTS SHALL be evaluated only in IDLE; CTS deassertion mid-frame SHALL NOT abort or stretch the frame.
REQ-028 tx_data/tx_valid changes after accept SHALL NOT affect the frame in progress.
REQ-029 tx_valid while busy SHALL be ignored (no queueing); the source holds it until tx_ready.

Reset
REQ-030 On reset high at a clock edge, state -> IDLE, counters -> 0, shift register -> 0, TX -> 1, busy -> 0, done -> 0, regardless of state.
REQ-031 Reset mid-frame SHALL abort the frame; TX high from the cycle after the reset edge; no done pulse.
REQ-032 tx_ready SHALL be 0 during reset and may assert the first cycle after reset deasserts if CTS=1.

Verification
REQ-033 Defaults, CTS=1, send 0x53 -> TX = 0,1,1,0,0,1,0,1,0,1 each 1085 cycles, total 10850 cycles, done pulses once on final stop cycle.
REQ-034 PARITY_ENABLE=1, PARITY_TYPE=0, send 0x53 -> parity bit 1, 11-bit frame; PARITY_TYPE=1 -> parity bit 0.
REQ-035 CTS=0 with tx_valid=1 and data 0xA5 for 5000 cycles -> tx_ready=0, TX=1, busy=0; raise CTS -> start bit next cycle, byte 0xA5 sent.
REQ-036 Back-to-back 0x00 then 0xFF with tx_valid held -> two frames separated by exactly 1 extra high cycle, two done pulses.
REQ-037 Assert reset for 1 cycle during DATA bit 3 of 0x53 -> TX=1 next cycle, busy=0, no done; subsequent 0x53 transmits correctly.
REQ-038 Drop CTS during DATA bit 2 -> frame completes unchanged with correct timing.
